// File: rtl/ni_inject_arbiter_if.sv
// Injection-port bundle: per-requester flit inputs with ready, plus the NoC local-port flit and credit lines.
interface ni_inject_arbiter_if #(
    parameter int N    = 2,
    parameter int V    = 2,
    parameter int Fpay = 32,
    parameter int Fw   = Fpay + V + 2
);
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_hdr;
    logic [N-1:0]      req_tail;
    logic [N*Fpay-1:0] req_data;
    logic [N-1:0]      req_ready;
    logic [Fw-1:0]     flit_out;
    logic              flit_out_wr;
    logic [V-1:0]      credit_in;

    modport master (
        output req_valid, req_hdr, req_tail, req_data, credit_in,
        input  req_ready, flit_out, flit_out_wr
    );

    modport slave (
        input  req_valid, req_hdr, req_tail, req_data, credit_in,
        output req_ready, flit_out, flit_out_wr
    );
endinterface

// File: rtl/ni_inject_arbiter.sv
// Packet-level round-robin scheduler for one NI injection port with per-VC credit tracking and wormhole lock.
// Optional stall watchdog (output err_timeout_o) is built only when NI_ARB_WATCHDOG_EN is defined.
module ni_inject_arbiter #(
    parameter int N    = 2,
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32,
    parameter int Fw   = Fpay + V + 2
`ifdef NI_ARB_WATCHDOG_EN
    ,
    parameter int TOw  = 8
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    ni_inject_arbiter_if.slave   port_if,
    output logic                 busy_o,
    output logic [$clog2(N)-1:0] grant_id_o,
    output logic                 err_proto_o,
    output logic                 err_credit_o
`ifdef NI_ARB_WATCHDOG_EN
    ,
    output logic                 err_timeout_o
`endif
);
    localparam int NW = $clog2(N);
    localparam int VW = (V > 1) ? $clog2(V) : 1;
    localparam int CW = $clog2(B + 1);

    // IDLE: arbitrate for a new packet (no transfer); SEND: grant locked until tail leaves
    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q;
    logic [NW-1:0]   grant_q, rr_ptr_q, pick_req, next_rr;
    logic [VW-1:0]   vc_sel_q, vc_ptr_q, pick_vc, next_vc;
    logic [CW-1:0]   credit_q [V];
    logic            first_q;
    logic [Fw-1:0]   flit_q;
    logic            flit_wr_q, err_proto_q, err_credit_q;

    logic [N-1:0]    elig;
    logic [V-1:0]    dec_vc, vc_onehot;
    logic            any_credit, start, xfer, wd_fire;
    logic            g_valid, g_hdr, g_tail;
    logic [Fpay-1:0] g_data;

    always_comb begin
        elig     = port_if.req_valid & port_if.req_hdr;
        pick_req = rr_ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr_q) + k) % N]) pick_req = NW'((int'(rr_ptr_q) + k) % N);
        end
        any_credit = 1'b0;
        pick_vc    = vc_ptr_q;
        for (int k = V - 1; k >= 0; k--) begin
            if (credit_q[(int'(vc_ptr_q) + k) % V] != '0) begin
                pick_vc    = VW'((int'(vc_ptr_q) + k) % V);
                any_credit = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid = port_if.req_valid[grant_q];
        g_hdr   = port_if.req_hdr[grant_q];
        g_tail  = port_if.req_tail[grant_q];
        g_data  = port_if.req_data[grant_q*Fpay +: Fpay];
        start   = (state_q == IDLE) && en_i && (|elig) && any_credit;
        xfer    = (state_q == SEND) && g_valid && (credit_q[vc_sel_q] != '0);
        next_rr = NW'((int'(grant_q) + 1) % N);
        next_vc = VW'((int'(vc_sel_q) + 1) % V);
        dec_vc    = '0;
        vc_onehot = '0;
        vc_onehot[vc_sel_q] = 1'b1;
        if (xfer) dec_vc[vc_sel_q] = 1'b1;
        port_if.req_ready = '0;
        if (xfer) port_if.req_ready[grant_q] = 1'b1;
    end

`ifdef NI_ARB_WATCHDOG_EN
    logic [TOw-1:0] wd_q;
    logic           err_timeout_q;

    assign wd_fire = (state_q == SEND) && !xfer && (&wd_q);

    // Counter idles at zero outside SEND, so entering SEND starts from a clean count
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= wd_fire;
            if (state_q != SEND || xfer) wd_q <= '0;
            else                         wd_q <= wd_q + 1'b1;
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            vc_sel_q     <= '0;
            vc_ptr_q     <= '0;
            first_q      <= 1'b0;
            flit_q       <= '0;
            flit_wr_q    <= 1'b0;
            err_proto_q  <= 1'b0;
            err_credit_q <= 1'b0;
            for (int v = 0; v < V; v++) credit_q[v] <= CW'(B);
        end else begin
            flit_wr_q <= xfer;
            if (xfer) flit_q <= {g_hdr, g_tail, vc_onehot, g_data};

            // A return and a send on the same VC in one cycle cancel out
            for (int v = 0; v < V; v++) begin
                if (port_if.credit_in[v] && !dec_vc[v]) begin
                    if (credit_q[v] == CW'(B)) err_credit_q <= 1'b1;
                    else                       credit_q[v]  <= credit_q[v] + 1'b1;
                end else if (dec_vc[v] && !port_if.credit_in[v]) begin
                    credit_q[v] <= credit_q[v] - 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SEND;
                        grant_q  <= pick_req;
                        vc_sel_q <= pick_vc;
                        first_q  <= 1'b1;
                    end else if (|(port_if.req_valid & ~port_if.req_hdr)) begin
                        err_proto_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        first_q <= 1'b0;
                        if (g_hdr && !first_q) err_proto_q <= 1'b1;
                        if (g_tail) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_rr;
                            vc_ptr_q <= next_vc;
                        end
                    end else if (wd_fire) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_rr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign port_if.flit_out    = flit_q;
    assign port_if.flit_out_wr = flit_wr_q;
    assign busy_o              = (state_q == SEND);
    assign grant_id_o          = grant_q;
    assign err_proto_o         = err_proto_q;
    assign err_credit_o        = err_credit_q;
endmodule

// File: tb/tb_ni_inject_arbiter.sv
// Bench for ni_inject_arbiter: cycle table from reset, directed multi-cycle sequences and a random packet scoreboard.
module tb_ni_inject_arbiter;
    localparam int N = 2, V = 2, B = 4, FPAY = 32, FW = FPAY + V + 2;
    localparam logic [35:0] F0 = 36'hD_A5A5_A5A5;
    localparam logic [35:0] F1 = 36'hE_1234_5678;

    logic clk = 1'b0;
    logic reset_i, en;
    logic busy, err_proto, err_credit;
    logic [$clog2(N)-1:0] grant_id;
`ifdef NI_ARB_WATCHDOG_EN
    logic err_timeout;
`endif

    always #5 clk = ~clk;

    ni_inject_arbiter_if #(.N(N), .V(V), .Fpay(FPAY)) bus ();

    ni_inject_arbiter #(.N(N), .V(V), .B(B), .Fpay(FPAY)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .en_i         (en),
        .port_if      (bus.slave),
        .busy_o       (busy),
        .grant_id_o   (grant_id),
        .err_proto_o  (err_proto),
        .err_credit_o (err_credit)
`ifdef NI_ARB_WATCHDOG_EN
        ,
        .err_timeout_o(err_timeout)
`endif
    );

    typedef struct {
        logic hdr;
        logic tail;
        logic [31:0] data;
    } flit_t;

    typedef struct {
        logic en; logic [1:0] valid, hdr, tail, cred; logic [31:0] d0, d1;
        logic [1:0] ready; logic wr; logic [35:0] flit; logic busy; logic gid; logic eproto;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    flit_t drv_q [N][$];
    flit_t exp_q [N][$];
    int outstanding [V];
    logic [V-1:0] ret_now, cred_force;
    logic [N-1:0] acc;
    int valid_pct, cmode, cyc, nobs, pkt_seq, cur_id;
    logic in_pkt;
    logic [V-1:0] pkt_vc;
    int head_id[$], head_vc[$], head_cyc[$], tail_cyc[$];
    vec_t tbl [10];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    task automatic add_pkt(int id, int len);
        flit_t f;
        for (int j = 0; j < len; j++) begin
            f.hdr  = (j == 0);
            f.tail = (j == len - 1);
            f.data = {4'(id), 12'(pkt_seq), 16'($urandom)};
            drv_q[id].push_back(f);
            exp_q[id].push_back(f);
        end
        pkt_seq++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        for (int v = 0; v < V; v++) outstanding[v] = 0;
        acc = '0; in_pkt = 1'b0; nobs = 0; cyc = 0; cred_force = '0; ret_now = '0;
        head_id.delete(); head_vc.delete(); head_cyc.delete(); tail_cyc.delete();
        bus.req_valid = '0; bus.req_hdr = '0; bus.req_tail = '0; bus.req_data = '0; bus.credit_in = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        en = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    task automatic observe();
        flit_t e;
        logic [31:0] d;
        logic [V-1:0] vc;
        int id, vi;
        d  = bus.flit_out[31:0];
        vc = bus.flit_out[33:32];
        id = int'(d[31:28]);
        vi = 0;
        for (int v = 0; v < V; v++) if (vc[v]) vi = v;
        nobs++;
        if (id >= N || exp_q[id].size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_flit: got %0h expected no flit", bus.flit_out);
            return;
        end
        e = exp_q[id].pop_front();
        chk("flit_content", bus.flit_out[35:0], {e.hdr, e.tail, 2'b00, e.data} | (36'(vc) << 32));
        chk("vc_onehot", $countones(vc), 1);
        chk("credit_limit", (outstanding[vi] + int'(ret_now[vi])) < B, 1);
        outstanding[vi]++;
        if (e.hdr) begin
            chk("head_while_open", in_pkt, 0);
            cur_id = id; pkt_vc = vc; in_pkt = 1'b1;
            head_id.push_back(id); head_vc.push_back(int'(vc)); head_cyc.push_back(cyc);
        end else begin
            chk("body_source", id, cur_id);
            chk("body_vc", vc, pkt_vc);
        end
        if (e.tail) begin
            in_pkt = 1'b0;
            tail_cyc.push_back(cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() > 0) begin
                bus.req_hdr[i]  = drv_q[i][0].hdr;
                bus.req_tail[i] = drv_q[i][0].tail;
                bus.req_data[i*FPAY +: FPAY] = drv_q[i][0].data;
                bus.req_valid[i] = ($urandom_range(99) < valid_pct);
            end else begin
                bus.req_valid[i] = 1'b0; bus.req_hdr[i] = 1'b0; bus.req_tail[i] = 1'b0;
            end
        end
        for (int v = 0; v < V; v++) begin
            case (cmode)
                1:       bus.credit_in[v] = (outstanding[v] > 0);
                2:       bus.credit_in[v] = (outstanding[v] > 0) && ($urandom_range(1) == 1);
                default: bus.credit_in[v] = cred_force[v];
            endcase
            ret_now[v] = bus.credit_in[v] && (outstanding[v] > 0);
            if (ret_now[v]) outstanding[v]--;
        end
        @(negedge clk);
        cyc++;
        acc = bus.req_ready & bus.req_valid;
        chk("ready_without_valid", bus.req_ready & ~bus.req_valid, 0);
        if (bus.flit_out_wr) observe();
    endtask

    task automatic run_until_drained(int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            step();
            n++;
        end
        if (pending() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d flits still expected, required 0", pending());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        valid_pct = 100; cmode = 0; pkt_seq = 0;
        tbl[0] = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 32'hA5A5A5A5, 32'h0, 2'b00, 1'b0, 36'h0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 32'hA5A5A5A5, 32'h0, 2'b01, 1'b0, 36'h0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'hA5A5A5A5, 32'h0, 2'b00, 1'b1, F0,    1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'h12345678, 2'b00, 1'b0, F0,    1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'h12345678, 2'b00, 1'b0, F0,    1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'h12345678, 2'b00, 1'b0, F0,    1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'h12345678, 2'b10, 1'b0, F0,    1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        2'b00, 1'b1, F1,    1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 32'h5, 32'h0,        2'b00, 1'b0, F1,    1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        2'b00, 1'b0, F1,    1'b0, 1'b1, 1'b1};

        do_reset();
        for (int r = 0; r < 10; r++) begin
            @(posedge clk);
            #1;
            en = tbl[r].en; bus.req_valid = tbl[r].valid; bus.req_hdr = tbl[r].hdr;
            bus.req_tail = tbl[r].tail; bus.credit_in = tbl[r].cred;
            bus.req_data = {tbl[r].d1, tbl[r].d0};
            @(negedge clk);
            chk("tbl_ready", bus.req_ready, tbl[r].ready);
            chk("tbl_wr", bus.flit_out_wr, tbl[r].wr);
            chk("tbl_flit", bus.flit_out, tbl[r].flit);
            chk("tbl_busy", busy, tbl[r].busy);
            chk("tbl_grant", grant_id, tbl[r].gid);
            chk("tbl_err_proto", err_proto, tbl[r].eproto);
        end

        // round robin with continuous 3-flit packets from both requesters
        do_reset(); cmode = 1; valid_pct = 100;
        add_pkt(0, 3); add_pkt(1, 3); add_pkt(0, 3); add_pkt(1, 3);
        run_until_drained(200);
        chk("rr_pkts", head_id.size(), 4);
        for (int k = 0; k < 4 && k < head_id.size(); k++) begin
            chk("rr_order", head_id[k], k % 2);
            chk("rr_vc", head_vc[k], (k % 2 == 1) ? 2 : 1);
        end
        for (int k = 0; k < 3 && k + 1 < head_cyc.size() && k < tail_cyc.size(); k++)
            chk("rr_gap", head_cyc[k+1] - tail_cyc[k], 2);

        // credit stall on VC0
        do_reset(); cmode = 0; valid_pct = 100;
        add_pkt(0, 5);
        repeat (10) step();
        chk("stall_sent", nobs, 4);
        chk("stall_ready", bus.req_ready[0], 0);
        chk("stall_busy", busy, 1);
        cred_force = 2'b01; step(); cred_force = 2'b00;
        chk("stall_ready_credit_cycle", bus.req_ready[0], 0);
        step();
        chk("stall_release_ready", bus.req_ready[0], 1);
        step();
        chk("stall_sent_all", nobs, 5);
        chk("stall_done_busy", busy, 0);

        // return on VC0 coincides with a send at credit 2; VC1 return at full credit overflows
        do_reset(); cmode = 0; valid_pct = 100;
        add_pkt(0, 6);
        repeat (3) step();
        chk("no_overflow_yet", err_credit, 0);
        cred_force = 2'b11; step(); cred_force = 2'b00;
        repeat (8) step();
        chk("simul_sent", nobs, 5);
        chk("simul_stalled", bus.req_ready[0], 0);
        chk("overflow_flag", err_credit, 1);

        // en dropped mid-packet
        do_reset(); cmode = 1; valid_pct = 100;
        add_pkt(0, 4); add_pkt(1, 2);
        repeat (3) step();
        en = 1'b0;
        repeat (12) step();
        chk("en_drop_sent", nobs, 4);
        chk("en_drop_busy", busy, 0);
        chk("en_drop_pending", exp_q[1].size(), 2);

        // reset mid-packet
        do_reset(); cmode = 0; valid_pct = 100;
        add_pkt(0, 5);
        repeat (3) step();
        chk("pre_reset_busy", busy, 1);
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wr", bus.flit_out_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flit", bus.flit_out, 0);
        reset_i = 1'b0;
        clear_model(); cmode = 0;
        add_pkt(0, 5);
        repeat (12) step();
        chk("rst_credit_restored", nobs, 4);

        // random traffic against the packet scoreboard
        do_reset(); cmode = 2; valid_pct = 75;
        for (int p = 0; p < 40; p++) add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)));
        run_until_drained(4000);
        step();
        chk("rand_err_proto", err_proto, 0);
        chk("rand_err_credit", err_credit, 0);
        chk("rand_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
